// File: rtl/clz_normalise.sv
// rtl/clz_normalise.sv - two-stage pipelined mantissa/exponent normaliser around a leading-zero counter

module clz #(
    parameter int half_bits_in = 8,
    localparam int bits_in     = 2 * half_bits_in,
    localparam int bits_out    = $clog2(bits_in)
) (
    input  logic [bits_in-1:0]  data,
    output logic [bits_out-1:0] lz,
    output logic                nz
);

    // Scan upward so the highest set bit is the last one to write lz.
    always_comb begin
        lz = '0;
        nz = 1'b0;
        for (int i = 0; i < bits_in; i++) begin
            if (data[i]) begin
                lz = bits_out'(bits_in - 1 - i);
                nz = 1'b1;
            end
        end
    end

endmodule

module clz_normalise #(
    parameter int half_bits_in = 8,
    localparam int bits_in     = 2 * half_bits_in,
    localparam int bits_out    = $clog2(bits_in)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bits_in-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bits_in-1:0]  out_mant,
    output logic [bits_out-1:0] out_exp,
    output logic                out_zero
);

    logic                a_valid_q, a_valid_d;
    logic [bits_in-1:0]  a_data_q, a_data_d;
    logic                b_valid_q, b_valid_d;
    logic [bits_in-1:0]  out_mant_q, out_mant_d;
    logic [bits_out-1:0] out_exp_q, out_exp_d;
    logic                out_zero_q, out_zero_d;

    logic [bits_out-1:0] lz;
    logic                nz;
    logic                b_advance;
    logic                in_fire;
    logic [bits_in-1:0]  mant;
    logic [bits_out-1:0] exp_val;

    clz #(.half_bits_in(half_bits_in)) u_clz (
        .data (a_data_q),
        .lz   (lz),
        .nz   (nz)
    );

    // in_ready looks through stage B so a full pipe still accepts while draining.
    assign b_advance = !b_valid_q || out_ready;
    assign in_ready  = !a_valid_q || b_advance;
    assign in_fire   = in_valid && in_ready;

    always_comb begin
        mant    = '0;
        exp_val = '0;
        if (nz) begin
            mant    = a_data_q << lz;
            exp_val = bits_out'(bits_in - 1) - lz;
        end
    end

    always_comb begin
        a_valid_d  = a_valid_q;
        a_data_d   = a_data_q;
        b_valid_d  = b_valid_q;
        out_mant_d = out_mant_q;
        out_exp_d  = out_exp_q;
        out_zero_d = out_zero_q;
        if (in_fire) begin
            a_valid_d = 1'b1;
            a_data_d  = in_data;
        end else if (b_advance) begin
            a_valid_d = 1'b0;
        end
        if (b_advance) begin
            b_valid_d  = a_valid_q;
            out_mant_d = mant;
            out_exp_d  = exp_val;
            out_zero_d = !nz;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_q  <= 1'b0;
            a_data_q   <= '0;
            b_valid_q  <= 1'b0;
            out_mant_q <= '0;
            out_exp_q  <= '0;
            out_zero_q <= 1'b0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_data_q   <= a_data_d;
            b_valid_q  <= b_valid_d;
            out_mant_q <= out_mant_d;
            out_exp_q  <= out_exp_d;
            out_zero_q <= out_zero_d;
        end
    end

    assign out_valid = b_valid_q;
    assign out_mant  = out_mant_q;
    assign out_exp   = out_exp_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_clz_normalise.sv
// tb/tb_clz_normalise.sv - scoreboard bench for clz_normalise

module tb_clz_normalise;

    typedef struct {
        logic [15:0] m;
        logic [3:0]  e;
        logic        z;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mant;
    logic [3:0]  out_exp;
    logic        out_zero;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    int last_pop = -10;
    int run = 0;
    exp_t sb[$];

    clz_normalise #(.half_bits_in(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] m, input logic [3:0] e, input logic z);
        exp_t r;
        r.m = m;
        r.e = e;
        r.z = z;
        return r;
    endfunction

    // Reference: shift left one place at a time until the MSB is set.
    function automatic exp_t ref_norm(input logic [15:0] d);
        exp_t r;
        int sh;
        sh = 0;
        r.m = d;
        r.e = 4'd0;
        r.z = 1'b1;
        if (d != 16'h0000) begin
            while (!r.m[15]) begin
                r.m = r.m << 1;
                sh++;
            end
            r.e = 4'(15 - sh);
            r.z = 1'b0;
        end else begin
            r.m = 16'h0000;
        end
        return r;
    endfunction

    // Monitor: a transfer happens on the next rising edge when both are high.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && out_valid && out_ready) begin
            pops++;
            if (cyc == last_pop + 1) run++;
            else run = 1;
            last_pop = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got mant 0x%0h with empty scoreboard, required no output", out_mant);
            end else begin
                e = sb.pop_front();
                check("out_mant", 32'(out_mant), 32'(e.m));
                check("out_exp", 32'(out_exp), 32'(e.e));
                check("out_zero", 32'(out_zero), 32'(e.z));
            end
        end
    end

    task automatic send(input logic [15:0] d, input exp_t e);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("send_accepted", 32'(accepted), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] bp_data [3];
    exp_t        bp_exp  [3];

    initial begin
        int   idx;
        int   acc;
        int   p0;
        logic stable_ok;
        logic have_ref;
        logic [20:0] ref_out;
        logic [15:0] rd;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_mant", 32'(out_mant), 32'd0);
        check("rst_out_exp", 32'(out_exp), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single word and latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0001;
        @(negedge clk);
        check("single_accept", 32'(in_ready), 32'd1);
        sb.push_back(mk(16'h8000, 4'd0, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_mant", 32'(out_mant), 32'h8000);
        check("single_out_exp", 32'(out_exp), 32'd0);
        idle(3);

        // Streaming back-to-back
        send(16'h8000, mk(16'h8000, 4'd15, 1'b0));
        send(16'h00F0, mk(16'hF000, 4'd7, 1'b0));
        send(16'h0000, mk(16'h0000, 4'd0, 1'b1));
        idle(4);
        check("stream_consecutive", 32'(run), 32'd3);

        // Backpressure
        bp_data[0] = 16'h0003; bp_exp[0] = mk(16'hC000, 4'd1, 1'b0);
        bp_data[1] = 16'h0300; bp_exp[1] = mk(16'hC000, 4'd9, 1'b0);
        bp_data[2] = 16'h3000; bp_exp[2] = mk(16'hC000, 4'd13, 1'b0);
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        stable_ok = 1'b1;
        have_ref = 1'b0;
        ref_out = '0;
        in_valid = 1'b1;
        in_data = bp_data[0];
        repeat (6) begin
            @(negedge clk);
            if (out_valid) begin
                if (!have_ref) begin
                    ref_out = {out_mant, out_exp, out_zero};
                    have_ref = 1'b1;
                end else if ({out_mant, out_exp, out_zero} !== ref_out) begin
                    stable_ok = 1'b0;
                end
            end
            if (in_ready && idx < 3) begin
                sb.push_back(bp_exp[idx]);
                idx++;
                acc++;
            end
            @(posedge clk);
            #1;
            if (idx < 3) in_data = bp_data[idx];
        end
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_stable", 32'(stable_ok), 32'd1);
        check("bp_hold_out", 32'({out_mant, out_exp, out_zero}), 32'({16'hC000, 4'd1, 1'b0}));
        p0 = pops;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && idx < 3; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        idle(4);
        check("bp_drain_count", 32'(pops - p0), 32'd3);

        // Single-bit sweep and random words
        for (int k = 0; k < 16; k++) begin
            rd = 16'h0001 << k;
            send(rd, mk(16'h8000, 4'(k), 1'b0));
        end
        for (int k = 0; k < 24; k++) begin
            rd = 16'($urandom);
            if (k % 5 == 0) rd = rd >> (k % 13);
            send(rd, ref_norm(rd));
        end
        idle(4);

        // Reset mid-operation
        out_ready = 1'b0;
        send(16'h1234, mk(16'h91A0, 4'd12, 1'b0));
        send(16'h0010, mk(16'h8000, 4'd4, 1'b0));
        idle(1);
        check("pre_rst_full", 32'({out_valid, in_ready}), 32'b10);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", 32'({out_mant, out_exp, out_zero}), 32'd0);
        sb.delete();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        p0 = pops;
        out_ready = 1'b1;
        idle(5);
        check("midrst_no_stale", 32'(pops - p0), 32'd0);

        // Pipeline still works after reset
        send(16'h0100, mk(16'h8000, 4'd8, 1'b0));
        idle(3);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
